// File: rtl/tnn_infer_ctrl.sv
// Sequencer around a combinational TNN classifier: serial feature load, multicycle
// settle, registered prediction capture, valid/ready result port and per-class hit counters.
module tnn_infer_ctrl #(
  parameter int FEAT_CNT    = 19,
  parameter int FEAT_BITS   = 4,
  parameter int CLASS_CNT   = 3,
  parameter int EVAL_CYCLES = 2,
  parameter int CNT_BITS    = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [FEAT_BITS-1:0]           s_feat,
  input  logic                           s_last,
  output logic [FEAT_CNT*FEAT_BITS-1:0]  clf_features,
  input  logic [$clog2(CLASS_CNT)-1:0]   clf_prediction,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [$clog2(CLASS_CNT)-1:0]   m_class,
  output logic [CNT_BITS-1:0]            m_index,
  output logic                           frame_err,
  input  logic                           hist_clr,
  input  logic [$clog2(CLASS_CNT)-1:0]   hist_sel,
  output logic [CNT_BITS-1:0]            hist_count
);

  localparam int CLS_W = $clog2(CLASS_CNT);
  localparam int IDX_W = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
  localparam int EC_W  = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;
  localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};

  typedef enum logic [1:0] {LOAD, EVAL, DONE} state_t;

  state_t                     state, state_next;
  logic [IDX_W-1:0]           idx;
  logic [EC_W-1:0]            eval_cnt;
  logic                       accept, beat_final, retire;
  logic [CLASS_CNT-1:0][CNT_BITS-1:0] class_cnt;

  assign accept     = (state == LOAD) && s_valid;
  assign beat_final = (idx == IDX_W'(FEAT_CNT - 1));
  assign retire     = (state == DONE) && m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    case (state)
      LOAD: begin
        s_ready = 1'b1;
        if (s_valid && beat_final && s_last) state_next = EVAL;
      end
      EVAL: if (eval_cnt == '0) state_next = DONE;
      DONE: if (m_ready) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  // A misaligned s_last (early or missing) drops the vector and restarts at slot 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      eval_cnt  <= '0;
      frame_err <= 1'b0;
      m_valid   <= 1'b0;
      m_class   <= '0;
    end else begin
      frame_err <= accept && (beat_final != s_last);
      if (accept) begin
        idx <= (beat_final || s_last) ? '0 : idx + IDX_W'(1);
        if (beat_final && s_last) eval_cnt <= EC_W'(EVAL_CYCLES - 1);
      end
      if (state == EVAL) begin
        if (eval_cnt == '0) begin
          m_valid <= 1'b1;
          m_class <= clf_prediction;
        end else begin
          eval_cnt <= eval_cnt - EC_W'(1);
        end
      end
      if (retire) m_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        m_index <= '0;
    else if (hist_clr) m_index <= '0;
    else if (retire)   m_index <= m_index + CNT_BITS'(1);
  end

  genvar gi;
  generate
    for (gi = 0; gi < FEAT_CNT; gi++) begin : g_slot
      logic [FEAT_BITS-1:0] slot;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                slot <= '0;
        else if (accept && idx == IDX_W'(gi))      slot <= s_feat;
      end
      assign clf_features[gi*FEAT_BITS +: FEAT_BITS] = slot;
    end

    // Saturating hit counters; a clear in the same cycle beats the increment.
    for (gi = 0; gi < CLASS_CNT; gi++) begin : g_cnt
      logic [CNT_BITS-1:0] cnt;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        cnt <= '0;
        else if (hist_clr) cnt <= '0;
        else if (retire && m_class == CLS_W'(gi) && cnt != CNT_MAX)
          cnt <= cnt + CNT_BITS'(1);
      end
      assign class_cnt[gi] = cnt;
    end
  endgenerate

  always_comb begin
    hist_count = '0;
    for (int i = 0; i < CLASS_CNT; i++)
      if (hist_sel == CLS_W'(i)) hist_count = class_cnt[i];
  end

endmodule

// File: tb/tb_tnn_infer_ctrl.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor pops and compares.
// A second instance with CNT_BITS=2 shares all inputs to exercise wrap and saturation.
module tb_tnn_infer_ctrl;
  localparam int FC = 19, FB = 4, CC = 3, EC = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b1, hist_clr = 1'b0;
  logic [FB-1:0] s_feat = '0;
  logic [1:0] hist_sel = '0;

  logic s_ready_a, s_ready_b, m_valid_a, m_valid_b, frame_err_a, frame_err_b;
  logic [FC*FB-1:0] feat_a, feat_b;
  logic [1:0] pred_a, pred_b, m_class_a, m_class_b;
  logic [15:0] m_index_a, hist_count_a;
  logic [1:0]  m_index_b, hist_count_b;

  function automatic logic [1:0] classify(input logic [FC*FB-1:0] f);
    int s = 0;
    for (int i = 0; i < FC; i++) s += int'(f[i*FB +: FB]);
    return 2'(s % 3);
  endfunction

  assign pred_a = classify(feat_a);
  assign pred_b = classify(feat_b);

  tnn_infer_ctrl #(.FEAT_CNT(FC), .FEAT_BITS(FB), .CLASS_CNT(CC), .EVAL_CYCLES(EC), .CNT_BITS(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_a), .s_feat(s_feat),
    .s_last(s_last), .clf_features(feat_a), .clf_prediction(pred_a), .m_valid(m_valid_a),
    .m_ready(m_ready), .m_class(m_class_a), .m_index(m_index_a), .frame_err(frame_err_a),
    .hist_clr(hist_clr), .hist_sel(hist_sel), .hist_count(hist_count_a));

  tnn_infer_ctrl #(.FEAT_CNT(FC), .FEAT_BITS(FB), .CLASS_CNT(CC), .EVAL_CYCLES(EC), .CNT_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_b), .s_feat(s_feat),
    .s_last(s_last), .clf_features(feat_b), .clf_prediction(pred_b), .m_valid(m_valid_b),
    .m_ready(m_ready), .m_class(m_class_b), .m_index(m_index_b), .frame_err(frame_err_b),
    .hist_clr(hist_clr), .hist_sel(hist_sel), .hist_count(hist_count_b));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       cls;
    logic [15:0]      ia;
    logic [1:0]       ib;
    logic [FC*FB-1:0] f;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0, bad = 0;
  logic [15:0] exp_idx = '0;
  int          cnt_a[CC], cnt_b[CC];
  logic [FB-1:0] vec [FC];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: one pop per result handshake, plus the no-overlap invariant.
  always @(negedge clk) begin
    if (rst_n && m_valid_a) begin
      check("no_overlap", {79'd0, s_ready_a}, 80'd0);
      check("b_valid_match", {79'd0, m_valid_b}, 80'd1);
      if (m_ready) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_result actual=class%0d required=none", m_class_a);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("m_class", {78'd0, m_class_a}, {78'd0, e.cls});
          check("m_index", {64'd0, m_index_a}, {64'd0, e.ia});
          check("m_index_b", {78'd0, m_index_b}, {78'd0, e.ib});
          check("features", {4'd0, feat_a}, {4'd0, e.f});
          $display("result idx=%0d class=%0d idx_b=%0d", m_index_a, m_class_a, m_index_b);
        end
      end
    end
  end

  task automatic clear_model();
    exp_idx = '0;
    for (int c = 0; c < CC; c++) begin cnt_a[c] = 0; cnt_b[c] = 0; end
  endtask

  task automatic do_reset();
    check("drained_before_reset", 80'(sbq.size()), 80'd0);
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; hist_clr = 1'b0; m_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_model();
  endtask

  task automatic beat(input logic [FB-1:0] f, input logic l);
    int n = 0;
    s_valid = 1'b1; s_feat = f; s_last = l;
    while (!s_ready_a && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) begin total++; bad++; $display("FAIL beat_timeout actual=%0d required=<200", n); end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_vec(input bit push, input bit chk_lat);
    logic [FC*FB-1:0] f;
    exp_t e;
    for (int i = 0; i < FC; i++) f[i*FB +: FB] = vec[i];
    for (int i = 0; i < FC - 1; i++) beat(vec[i], 1'b0);
    if (push) begin
      e.cls = classify(f); e.ia = exp_idx; e.ib = exp_idx[1:0]; e.f = f;
      sbq.push_back(e);
      exp_idx++;
      if (cnt_a[e.cls] < 65535) cnt_a[e.cls]++;
      if (cnt_b[e.cls] < 3) cnt_b[e.cls]++;
    end
    beat(vec[FC-1], 1'b1);
    check("no_frame_err", {79'd0, frame_err_a}, 80'd0);
    if (chk_lat)
      for (int k = 1; k <= EC; k++) begin
        @(posedge clk); #1;
        check("latency", {79'd0, m_valid_a}, {79'd0, (k == EC)});
      end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sbq.size() != 0 || m_valid_a) && n < 500) begin @(posedge clk); #1; n++; end
    check("drain", {79'd0, (sbq.size() == 0 && !m_valid_a)}, 80'd1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!m_valid_a && n < 50) begin @(posedge clk); #1; n++; end
    check("wait_valid", {79'd0, m_valid_a}, 80'd1);
  endtask

  initial begin
    bit seen;
    clear_model();
    // 1: reset state and a clean vector with a hand-computed feature bus
    do_reset();
    check("rst_s_ready", {79'd0, s_ready_a}, 80'd1);
    check("rst_m_valid", {79'd0, m_valid_a}, 80'd0);
    check("rst_m_index", {64'd0, m_index_a}, 80'd0);
    check("rst_frame_err", {79'd0, frame_err_a}, 80'd0);
    check("rst_features", {4'd0, feat_a}, 80'd0);
    check("rst_hist", {64'd0, hist_count_a}, 80'd0);
    for (int i = 0; i < FC; i++) vec[i] = 4'(i % 16);
    send_vec(1'b1, 1'b1);
    check("t1_features", {4'd0, feat_a}, 80'h210FEDCBA9876543210);
    check("t1_class", {78'd0, m_class_a}, 80'd0);
    wait_idle();

    // 2: early s_last on beat 5
    do_reset();
    for (int i = 0; i < 4; i++) beat(4'(i), 1'b0);
    beat(4'd4, 1'b1);
    check("t2_frame_err", {79'd0, frame_err_a}, 80'd1);
    @(posedge clk); #1;
    check("t2_frame_pulse", {79'd0, frame_err_a}, 80'd0);
    repeat (5) @(posedge clk);
    #1 check("t2_no_valid", {79'd0, m_valid_a}, 80'd0);
    for (int i = 0; i < FC; i++) vec[i] = 4'((i * 3) % 16);
    send_vec(1'b1, 1'b1);
    wait_idle();

    // 3: missing s_last; the next beat starts a fresh vector
    for (int i = 0; i < FC; i++) beat(4'(i % 16), 1'b0);
    check("t3_frame_err", {79'd0, frame_err_a}, 80'd1);
    for (int i = 0; i < FC; i++) vec[i] = 4'(15 - (i % 16));
    send_vec(1'b1, 1'b0);
    wait_idle();

    // 4: result back-pressure
    m_ready = 1'b0;
    for (int i = 0; i < FC; i++) vec[i] = 4'(i % 5);
    send_vec(1'b1, 1'b0);
    wait_valid();
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("t4_s_ready", {79'd0, s_ready_a}, 80'd0);
      check("t4_class", {78'd0, m_class_a}, {78'd0, sbq[0].cls});
      check("t4_index", {64'd0, m_index_a}, {64'd0, sbq[0].ia});
    end
    m_ready = 1'b1;
    wait_idle();

    // 5: wrap of a 2-bit index and saturation of a 2-bit counter
    do_reset();
    for (int i = 0; i < FC; i++) vec[i] = '0;
    vec[0] = 4'd2;
    for (int r = 0; r < 5; r++) send_vec(1'b1, 1'b0);
    wait_idle();
    hist_sel = 2'd2; #1;
    check("t5_hist_b_sat", {78'd0, hist_count_b}, 80'd3);
    check("t5_hist_a", {64'd0, hist_count_a}, 80'd5);
    check("t5_hist_b_model", {78'd0, hist_count_b}, 80'(cnt_b[2]));
    hist_sel = 2'd0; #1;
    check("t5_hist_a0", {64'd0, hist_count_a}, 80'(cnt_a[0]));
    hist_sel = 2'd3; #1;
    check("t5_hist_oob_a", {64'd0, hist_count_a}, 80'd0);
    check("t5_hist_oob_b", {78'd0, hist_count_b}, 80'd0);

    // 6: clear on the handshake cycle, then reset during evaluation
    m_ready = 1'b0;
    for (int i = 0; i < FC; i++) vec[i] = 4'd1;
    send_vec(1'b1, 1'b0);
    wait_valid();
    m_ready = 1'b1; hist_clr = 1'b1;
    @(posedge clk); #1;
    hist_clr = 1'b0;
    clear_model();
    check("t6_retired", {79'd0, m_valid_a}, 80'd0);
    check("t6_index_a", {64'd0, m_index_a}, 80'd0);
    check("t6_index_b", {78'd0, m_index_b}, 80'd0);
    for (int s = 0; s < CC; s++) begin
      hist_sel = 2'(s); #1;
      check("t6_hist_clr", {64'd0, hist_count_a}, 80'd0);
    end
    for (int i = 0; i < FC; i++) vec[i] = 4'(i % 7);
    send_vec(1'b0, 1'b0);
    rst_n = 1'b0; #3; rst_n = 1'b1;
    clear_model();
    seen = 1'b0;
    repeat (10) begin @(posedge clk); #1; if (m_valid_a) seen = 1'b1; end
    check("t6_rst_no_valid", {79'd0, seen}, 80'd0);
    check("t6_rst_s_ready", {79'd0, s_ready_a}, 80'd1);
    send_vec(1'b1, 1'b1);
    wait_idle();
    check("final_queue", 80'(sbq.size()), 80'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=%0t required=<500000", $time);
    $fatal(1, "timeout");
  end
endmodule
